// File: rtl/adder_rr_scheduler.sv
// adder_rr_scheduler: round-robin arbiter that shares one registered adder among NREQ requesters
// Ports: clk, reset (asynchronous, active-high)
//        req_valid/req_ready   per-requester handshake, at most one ready bit high per cycle
//        req_a/req_b/req_cin   packed operands, requester i at [i*WIDTH +: WIDTH]
//        rsp_valid/rsp_ready   response handshake carrying rsp_id, rsp_sum, rsp_cout
//        busy                  high whenever the FSM is not in IDLE
module adder_rr_scheduler #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_cin,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
    state_t state, next_state;
    logic [IDW-1:0]   rr_ptr, win, idx, op_id;
    logic             found, op_cin;
    logic [WIDTH-1:0] op_a, op_b;
    // search starts just past the previous winner so every requester rotates to top priority
    always_comb begin
        found = 1'b0;
        win = '0;
        idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDW'((int'(rr_ptr) + k) % NREQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win = idx;
            end
        end
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= next_state;
    // reset gates req_ready so no handshake is offered while the block is held in reset
    always_comb begin
        next_state = (state == IDLE && found) ? CALC :
                     (state == CALC)          ? RESP :
                     (state == RESP && rsp_ready) ? IDLE : state;
        req_ready = (state == IDLE && found && !reset) ? (NREQ'(1) << win) : '0;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            rr_ptr   <= IDW'(NREQ - 1);
            op_a     <= '0;
            op_b     <= '0;
            op_cin   <= 1'b0;
            op_id    <= '0;
            rsp_sum  <= '0;
            rsp_cout <= 1'b0;
            rsp_id   <= '0;
        end else begin
            if (state == IDLE && found) begin
                op_a   <= req_a[win*WIDTH +: WIDTH];
                op_b   <= req_b[win*WIDTH +: WIDTH];
                op_cin <= req_cin[win];
                op_id  <= win;
                rr_ptr <= win;
            end
            if (state == CALC) begin
                {rsp_cout, rsp_sum} <= {1'b0, op_a} + {1'b0, op_b} + (WIDTH+1)'(op_cin);
                rsp_id <= op_id;
            end
        end
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);
    always_ff @(posedge clk)
        assert (IDW == $clog2(NREQ)) else $error("adder_rr_scheduler: IDW must equal clog2(NREQ)");
endmodule

// File: tb/tb_adder_rr_scheduler.sv
// tb_adder_rr_scheduler: scoreboard bench for adder_rr_scheduler with a transaction-level reference model
module tb_adder_rr_scheduler;
    localparam int WIDTH = 8;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;
    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req_valid, req_ready, req_cin;
    logic [NREQ*WIDTH-1:0] req_a, req_b;
    logic                  rsp_valid, rsp_ready, rsp_cout, busy;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_sum;
    adder_rr_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
        .busy(busy)
    );
    always #5 clk = ~clk;
    typedef struct { int id; int sum; int cout; } rsp_t;
    rsp_t exp_q[$];
    int vectors = 0;
    int miscompares = 0;
    int gcount [NREQ];
    int g3_req = 0;
    int g3_want = 0;
    function automatic void chk(string nm, logic [31:0] act, logic [31:0] ex);
        vectors++;
        if (act !== ex) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, ex, $time);
        end
    endfunction
    // reference: one transaction in flight; response two cycles after grant; round-robin by index
    initial begin
        int m_ptr, m_age, win, g3_seen, tot;
        bit m_busy;
        logic [NREQ-1:0] exp_rdy;
        logic [IDW-1:0] j;
        rsp_t r;
        m_ptr = NREQ - 1; m_age = 0; m_busy = 0; g3_seen = 0;
        for (int i = 0; i < NREQ; i++) gcount[i] = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                m_busy = 0; m_age = 0; m_ptr = NREQ - 1;
                chk("rst_req_ready", 32'(req_ready), 0);
                chk("rst_rsp_valid", 32'(rsp_valid), 0);
                chk("rst_rsp_sum", 32'(rsp_sum), 0);
                chk("rst_rsp_cout", 32'(rsp_cout), 0);
                chk("rst_rsp_id", 32'(rsp_id), 0);
                chk("rst_busy", 32'(busy), 0);
            end else begin
                if (m_busy) m_age++;
                win = -1;
                exp_rdy = '0;
                if (!m_busy)
                    for (int k = 1; k <= NREQ; k++) begin
                        j = IDW'((m_ptr + k) % NREQ);
                        if (win < 0 && req_valid[j]) win = int'(j);
                    end
                if (win >= 0) exp_rdy[IDW'(win)] = 1'b1;
                chk("req_ready", 32'(req_ready), 32'(exp_rdy));
                chk("busy", 32'(busy), 32'(m_busy));
                chk("rsp_valid", 32'(rsp_valid), 32'(m_busy && m_age >= 2));
                if (rsp_valid) begin
                    if (exp_q.size() == 0) chk("spurious_rsp", 1, 0);
                    else begin
                        chk("rsp_id", 32'(rsp_id), exp_q[0].id);
                        chk("rsp_sum", 32'(rsp_sum), exp_q[0].sum);
                        chk("rsp_cout", 32'(rsp_cout), exp_q[0].cout);
                    end
                end
                if (m_busy && m_age >= 2 && rsp_ready) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    m_busy = 0;
                end
                if (win >= 0) begin
                    j = IDW'(win);
                    tot = int'(req_a[j*WIDTH +: WIDTH]) + int'(req_b[j*WIDTH +: WIDTH]) + int'(req_cin[j]);
                    r.id = win; r.sum = tot % (1 << WIDTH); r.cout = tot >> WIDTH;
                    exp_q.push_back(r);
                    m_busy = 1; m_age = 0; m_ptr = win;
                    gcount[win]++;
                end
                if (g3_req != g3_seen) begin
                    chk("withdrawn_req3_grants", gcount[3], g3_want);
                    g3_seen = g3_req;
                end
            end
        end
    end
    task automatic step();
        logic [NREQ-1:0] g;
        #3;
        g = req_ready & req_valid;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~g;
    endtask
    task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
        req_cin[IDW'(i)] = c;
        req_valid[IDW'(i)] = 1'b1;
    endtask
    task automatic wait_idle();
        int n;
        n = 0;
        step();
        while ((busy || rsp_valid || req_valid != '0) && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) begin
            $display("FAIL wait_idle: got busy=%0b expected idle within 100 cycles", busy);
            $fatal(1, "timeout");
        end
    endtask
    initial begin
        int g3_before;
        reset = 1'b1; rsp_ready = 1'b1;
        req_valid = '0; req_a = '0; req_b = '0; req_cin = '0;
        repeat (2) step();
        reset = 1'b0;
        step();
        set_req(0, 8'h12, 8'h34, 1'b0);
        wait_idle();
        set_req(2, 8'hFF, 8'h01, 1'b0);
        wait_idle();
        set_req(2, 8'hFF, 8'hFF, 1'b1);
        wait_idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
        repeat (15) begin
            step();
            for (int i = 0; i < NREQ; i++)
                if (!req_valid[IDW'(i)]) set_req(i, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
        end
        req_valid = '0;
        wait_idle();
        rsp_ready = 1'b0;
        set_req(1, 8'hA5, 8'h5A, 1'b1);
        step();
        set_req(0, 8'h80, 8'h80, 1'b0);
        repeat (7) step();
        rsp_ready = 1'b1;
        wait_idle();
        set_req(3, 8'h77, 8'h11, 1'b0);
        step();
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        step();
        set_req(1, 8'h0F, 8'hF0, 1'b1);
        wait_idle();
        set_req(0, 8'h01, 8'h02, 1'b0);
        set_req(1, 8'h03, 8'h04, 1'b1);
        wait_idle();
        g3_before = gcount[3];
        set_req(0, 8'h10, 8'h20, 1'b0);
        step();
        set_req(3, 8'hEE, 8'hEE, 1'b1);
        step();
        req_valid[3] = 1'b0;
        wait_idle();
        g3_want = g3_before;
        g3_req++;
        step();
        repeat (600) begin
            for (int i = 0; i < NREQ; i++)
                if (!req_valid[IDW'(i)] && $urandom_range(3) == 0)
                    set_req(i, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
                else if (req_valid[IDW'(i)] && $urandom_range(15) == 0)
                    req_valid[IDW'(i)] = 1'b0;
            rsp_ready = ($urandom_range(2) != 0);
            step();
        end
        rsp_ready = 1'b1;
        req_valid = '0;
        wait_idle();
        repeat (2) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
